// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with per-transfer round-robin grant.
// Optional slave-ack watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_o,
    output logic [DW-1:0] m0_dat_i,
    output logic          m0_ack,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_o,
    output logic [DW-1:0] m1_dat_i,
    output logic          m1_ack,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    output logic [1:0]    gnt,
    output logic          timeout
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   m0_req, m1_req;
    logic   g0, g1;
    logic   to_hit;
    logic   done;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT must be >= 2");
    end

    assign m0_req = m0_cyc & m0_stb;
    assign m1_req = m1_cyc & m1_stb;
    assign g0     = (state_q == GNT0);
    assign g1     = (state_q == GNT1);
    assign gnt    = state_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign to_hit = ((g0 & m0_cyc) | (g1 & m1_cyc)) & (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if ((state_d != state_q) || s_ack || to_hit || (state_q == IDLE)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign timeout = to_hit;
    assign done    = s_ack | to_hit;

    // Slave side sees only the granted master; everything is zero while idle.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        if (g0) begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_dat_o = m0_dat_o;
        end else if (g1) begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_dat_o = m1_dat_o;
        end
    end

    // An ack reaches a master only while it is granted and still holds cyc.
    assign m0_ack   = g0 & m0_cyc & done;
    assign m1_ack   = g1 & m1_cyc & done;
    assign m0_dat_i = (g0 & to_hit) ? '0 : s_dat_i;
    assign m1_dat_i = (g1 & to_hit) ? '0 : s_dat_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || last_q)) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_d = IDLE;
                end else if (done) begin
                    last_d = 1'b0;
                    if (m1_req) begin
                        state_d = GNT1;
                    end else if (!m0_req) begin
                        state_d = IDLE;
                    end
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_d = IDLE;
                end else if (done) begin
                    last_d = 1'b1;
                    if (m0_req) begin
                        state_d = GNT0;
                    end else if (!m1_req) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
